// File: rtl/fp_simd_issue_pkg.sv
// Shared definitions for the FP_SIMD issue sequencer: opcodes, lane format,
// reference float constants and the sequencer FSM encoding.
package fp_simd_issue_pkg;

    // Lane width of the downstream FP_SIMD engine.
    localparam int ENGINE_FP_W = 22;

    // Engine opcodes. Values outside this set are forwarded unchanged.
    localparam logic [2:0] op_add        = 3'd0;
    localparam logic [2:0] op_sub        = 3'd1;
    localparam logic [2:0] op_mul        = 3'd2;
    localparam logic [2:0] op_reduce_add = 3'd3;

    // Lane format: sign[21], exponent[20:13] (bias 127), mantissa[12:0].
    localparam logic [ENGINE_FP_W-1:0] fp_zero      = 22'h000000;
    localparam logic [ENGINE_FP_W-1:0] fp_half      = 22'h0FC000;
    localparam logic [ENGINE_FP_W-1:0] fp_one       = 22'h0FE000;
    localparam logic [ENGINE_FP_W-1:0] fp_onehalf   = 22'h0FF000;
    localparam logic [ENGINE_FP_W-1:0] fp_two       = 22'h100000;
    localparam logic [ENGINE_FP_W-1:0] fp_twohalf   = 22'h100800;
    localparam logic [ENGINE_FP_W-1:0] fp_three     = 22'h101000;
    localparam logic [ENGINE_FP_W-1:0] fp_threehalf = 22'h101800;
    localparam logic [ENGINE_FP_W-1:0] fp_four      = 22'h102000;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_simd_issue_if.sv
// Bundle of the command stream, engine drive/return and result stream of the
// issue sequencer. The sequencer uses the slave view, its environment the master view.
interface fp_simd_issue_if import fp_simd_issue_pkg::*; #(
    parameter int SIMD_WIDTH = 4,
    parameter int FP_W       = ENGINE_FP_W,
    parameter int DEPTH      = 4
) ();
    localparam int VW = SIMD_WIDTH * FP_W;
    localparam int CW = $clog2(DEPTH + 1);

    // Command stream from the pipeline.
    logic          s_valid;
    logic          s_ready;
    logic [2:0]    s_opcode;
    logic [VW-1:0] s_in1;
    logic [VW-1:0] s_in2;
    // Engine drive and return.
    logic          o_en;
    logic [2:0]    o_opcode;
    logic [VW-1:0] o_in1;
    logic [VW-1:0] o_in2;
    logic [VW-1:0] i_result;
    logic          i_valid;
    logic          i_busy;
    // Result stream and status.
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_data;
    logic [2:0]    m_opcode;
    logic [CW-1:0] o_count;
    logic          o_timeout;

    modport slave (
        input  s_valid, s_opcode, s_in1, s_in2, i_result, i_valid, i_busy, m_ready,
        output s_ready, o_en, o_opcode, o_in1, o_in2, m_valid, m_data, m_opcode,
               o_count, o_timeout
    );

    modport master (
        output s_valid, s_opcode, s_in1, s_in2, i_result, i_valid, i_busy, m_ready,
        input  s_ready, o_en, o_opcode, o_in1, o_in2, m_valid, m_data, m_opcode,
               o_count, o_timeout
    );
endinterface

// File: rtl/fp_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), pointers wrap naturally, no bypass.
module fp_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; entries carry no reset since occupancy decides what is valid.
    // NOTE: the memory array is deliberately left out of reset; only pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fp_simd_issue.sv
// Issue sequencer in front of the FP_SIMD engine: queues commands, issues them
// one at a time, watches for a hung engine and returns results in order.
// Optional performance counters are enabled with `define FP_SIMD_ISSUE_PERF_EN.
module fp_simd_issue import fp_simd_issue_pkg::*; #(
    parameter int SIMD_WIDTH = 4,
    parameter int FP_W       = ENGINE_FP_W,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    fp_simd_issue_if.slave     bus
`ifdef FP_SIMD_ISSUE_PERF_EN
    ,
    output logic [31:0]        o_perf_busy_cycles,
    output logic [15:0]        o_perf_ops
`endif
);
    localparam int VW  = SIMD_WIDTH * FP_W;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [2:0]    opcode;
        logic [VW-1:0] in1;
        logic [VW-1:0] in2;
    } cmd_t;

    cmd_t           push_cmd, head_cmd;
    logic           fifo_full, fifo_empty, fifo_pop;
    state_e         state_q;
    logic           o_en_q, m_valid_q, timeout_q;
    logic [2:0]     opcode_q, m_opcode_q;
    logic [VW-1:0]  in1_q, in2_q, m_data_q;
    logic [WDW-1:0] wd_q;

    assign push_cmd = '{opcode: bus.s_opcode, in1: bus.s_in1, in2: bus.s_in2};
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !bus.i_busy;

    fp_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.s_valid && !fifo_full),
        .pop_i   (fifo_pop),
        .wdata_i (push_cmd),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.o_count)
    );

    // Issue FSM with watchdog and result capture; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            o_en_q     <= 1'b0;
            opcode_q   <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            wd_q       <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_opcode_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        opcode_q <= head_cmd.opcode;
                        in1_q    <= head_cmd.in1;
                        in2_q    <= head_cmd.in2;
                        state_q  <= ST_ISSUE;
                    end
                end
                // The engine's valid may still be stale here, so it is not looked at.
                ST_ISSUE: begin
                    o_en_q  <= 1'b1;
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                // A result beats an expiring watchdog in the same cycle.
                ST_WAIT: begin
                    if (bus.i_valid) begin
                        m_data_q   <= bus.i_result;
                        m_opcode_q <= opcode_q;
                        m_valid_q  <= 1'b1;
                        o_en_q     <= 1'b0;
                        state_q    <= ST_HOLD;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        o_en_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = !fifo_full;
    assign bus.o_en      = o_en_q;
    assign bus.o_opcode  = opcode_q;
    assign bus.o_in1     = in1_q;
    assign bus.o_in2     = in2_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_opcode  = m_opcode_q;
    assign bus.o_timeout = timeout_q;

`ifdef FP_SIMD_ISSUE_PERF_EN
    // Busy-cycle counter saturates; completed-result counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_busy_cycles <= '0;
            o_perf_ops         <= '0;
        end else begin
            if (state_q != ST_IDLE && o_perf_busy_cycles != '1)
                o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
            if (m_valid_q && bus.m_ready)
                o_perf_ops <= o_perf_ops + 16'd1;
        end
    end
`endif
endmodule

// File: doc/fp_simd_issue.md
Name: fp_simd_issue

Overview:
- Command-queue and issue sequencer directly upstream of the FP_SIMD vector engine.
- Buffers vector commands (opcode plus two SIMD_WIDTH×FP_W operand vectors) from the pipeline in a small FIFO.
- Drives the engine's enable/opcode/operand inputs one operation at a time and waits for the engine's valid.
- Returns each result on a valid/ready output port, in order.

Parameters:
- SIMD_WIDTH, 4: lanes per vector.
- FP_W, 22: bits per float lane; must match the engine.
- DEPTH, 4: command FIFO entries; power of 2, ≥2.
- TIMEOUT, 64: maximum WAIT cycles before an operation is abandoned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  command valid.
- s_ready  out  1  FIFO can accept.
- s_opcode  in  3  op_add/op_sub/op_mul/op_reduce_add.
- s_in1  in  SIMD_WIDTH*FP_W  operand A.
- s_in2  in  SIMD_WIDTH*FP_W  operand B.
- o_en  out  1  engine enable.
- o_opcode  out  3  engine opcode.
- o_in1  out  SIMD_WIDTH*FP_W  engine operand A.
- o_in2  out  SIMD_WIDTH*FP_W  engine operand B.
- i_result  in  SIMD_WIDTH*FP_W  engine output.
- i_valid  in  1  engine result valid.
- i_busy  in  1  engine busy.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer ready.
- m_data  out  SIMD_WIDTH*FP_W  captured result.
- m_opcode  out  3  opcode of the result.
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- o_timeout  out  1  one-cycle pulse when an operation is abandoned.

Behaviour:
- Reset (async, immediate): all outputs 0 except s_ready=1; FIFO emptied; FSM=IDLE. This applies mid-operation; an in-flight op is discarded.
- FIFO:
  - push = s_valid && s_ready; s_ready = !full. No bypass.
  - Push while full is impossible.
  - Push and pop in the same cycle: o_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM IDLE: if o_count>0 and !i_busy, pop head into issue registers (o_opcode/o_in1/o_in2); next state ISSUE. Otherwise stay.
- FSM ISSUE: o_en=1 (registered), watchdog cleared. i_valid is ignored this cycle because the engine may show a stale valid. Next state WAIT.
- FSM WAIT:
  - o_en held 1; o_opcode/o_in1/o_in2 held stable; watchdog increments.
  - On i_valid=1: capture i_result into m_data and o_opcode into m_opcode; o_en=0 next cycle; next state HOLD.
  - If the watchdog reaches TIMEOUT-1 without i_valid: o_timeout=1 for one cycle, o_en=0, command dropped, next state IDLE.
  - If i_valid and timeout coincide, i_valid wins.
- FSM HOLD: m_valid=1; m_data/m_opcode stable until m_ready. On m_valid && m_ready: m_valid=0 next cycle; next state IDLE.
- Spacing and latency:
  - o_en is low for ≥1 cycle between operations (IDLE is always visited).
  - Push at edge N → o_en high from cycle N+2.
  - i_valid at cycle K → m_valid from K+1.
- Results are returned in command order. m_data is passed through unmodified; for op_reduce_add only lane [SIMD_WIDTH*FP_W-1 -: FP_W] is meaningful.
- Opcodes are not checked; illegal values are forwarded to the engine as-is.

Optional Feature:
- Macro FP_SIMD_ISSUE_PERF_EN.
- When defined, adds ports:
  - o_perf_busy_cycles, out, 32: cycles with FSM≠IDLE, saturating.
  - o_perf_ops, out, 16: completed handshakes on m_valid&&m_ready, wrapping.
  - Both counters reset to 0.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Decomposition:
- ren_params gets:
  - opcode constants (op_add, op_sub, op_mul, op_reduce_add);
  - FP_W = 22 and the fp constants (fpONE etc.);
  - the FSM state encoding IDLE/ISSUE/WAIT/HOLD as 2-bit localparams.
- One sub-module, fp_cmd_fifo: parameterised width and DEPTH, push/pop/full/empty/count, async active-high reset.
- FSM, watchdog and result register live in fp_simd_issue.

Test Plan (bench wires a real FP_SIMD downstream; for the timeout case a stub engine that never asserts valid):
- Single add, m_ready=1. Stimulus: s_in1={fpONE,fpTWO,fpTWOHALF,fpTHREE}, s_in2={fpHALF,fpTWO,fpONE,fpONE}. Required: m_data={fpONEHALF,fpFOUR,fpTHREEHALF,fpFOUR}, m_opcode=op_add, o_en first high 2 cycles after push.
- Back-to-back add, mul, sub, reduce_add with the same operands, m_ready=1. Required, in order:
  - mul: {fpHALF,fpFOUR,fpTWOHALF,fpTHREE};
  - sub: {fpHALF,0,fpONEHALF,fpTWO};
  - reduce_add: lane 3 = fpFOUR;
  - o_en low ≥1 cycle between ops.
- Fill: m_ready=0, push 6 commands. Required: 1st issued and held in HOLD, next 4 queued, o_count=4, s_ready=0, 6th stalled. Then m_ready=1 drains all 6 in order.
- Backpressure: m_ready=0 for 10 cycles after a result. Required: m_valid=1, m_data stable, o_en=0, no pop.
- Timeout: stub engine, TIMEOUT=8. Required: exactly one o_timeout pulse 8 cycles after ISSUE, o_en drops, the next queued command issues, no m_valid for the dropped one.
- Reset asserted during WAIT. Required, same cycle: o_en=0, m_valid=0, o_count=0, s_ready=1. After release, a new command completes normally.
